// File: rtl/dmem_mmio_pkg.sv
// -----------------------------------------------------------------------------
// dmem_mmio_pkg
// Shared constants for the data-memory stage: bus width, RAM and FIFO sizes,
// the memory-mapped register addresses and the STATUS bit positions. The core,
// software tests and the testbench all take their addresses from here.
// No ports (package).
// -----------------------------------------------------------------------------
package dmem_mmio_pkg;

    localparam int DMEM_DATA_W  = 32;
    localparam int DMEM_RAM_AW  = 8;
    localparam int DMEM_FIFO_AW = 2;

    localparam logic [31:0] MMIO_TXDATA = 32'h8000_0000;
    localparam logic [31:0] MMIO_STATUS = 32'h8000_0004;
    localparam logic [31:0] MMIO_CYCLE  = 32'h8000_0008;
    localparam logic [31:0] MMIO_DROPS  = 32'h8000_000C;

    localparam int STATUS_EMPTY_BIT = 0;
    localparam int STATUS_FULL_BIT  = 1;
    localparam int STATUS_COUNT_LSB = 8;

    // Which target a given address selects.
    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_TXDATA,
        SEL_STATUS,
        SEL_CYCLE,
        SEL_DROPS,
        SEL_NONE
    } dmemSel_e;

endpackage

// File: rtl/dmem_mmio_if.sv
// -----------------------------------------------------------------------------
// dmem_mmio_if
// Bundles the core-side load/store bus and the transmit byte stream.
//   addr     byte address from the core (aluout)
//   wdata    store data (writedata)
//   we       store strobe (memwrite)
//   rdata    combinational load data (readdata)
//   tx_data  head byte of the transmit FIFO
//   tx_valid transmit FIFO non-empty
//   tx_ready consumer accepts the head byte this cycle
// master: the side driving addresses and ready (core + consumer)
// slave : the data-memory stage
// -----------------------------------------------------------------------------
interface dmem_mmio_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic [DATA_W-1:0] rdata;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output addr, wdata, we, tx_ready,
        input  rdata, tx_data, tx_valid
    );

    modport slave (
        input  addr, wdata, we, tx_ready,
        output rdata, tx_data, tx_valid
    );
endinterface

// File: rtl/dmem_mmio_tx_fifo.sv
// -----------------------------------------------------------------------------
// tx_fifo
// Circular-buffer FIFO with read/write pointers and an occupancy count.
//   clk, rst_n  clock and asynchronous active-low reset
//   push_i      push request, data_i is the byte to enqueue
//   popReq_i    consumer ready; a pop only happens when non-empty
//   accept_o    push taken this cycle (room, or a pop frees a slot)
//   pop_o       pop taken this cycle
//   data_o      entry at the read pointer (don't-care when empty)
//   count_o     occupancy 0..2^AW
//   full_o      count == depth
//   empty_o     count == 0
// -----------------------------------------------------------------------------
module tx_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             popReq_i,
    output logic             accept_o,
    output logic             pop_o,
    output logic [WIDTH-1:0] data_o,
    output logic [AW:0]      count_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [AW:0]      count_q, count_d;
    logic             popFire;
    logic             pushFire;

    assign empty_o  = (count_q == '0);
    assign full_o   = (count_q == DEPTH[AW:0]);
    assign popFire  = popReq_i & ~empty_o;
    // When full, a simultaneous pop frees the head slot, which is exactly
    // where the write pointer points, so the new byte can take it.
    assign pushFire = push_i & (~full_o | popFire);

    assign accept_o = pushFire;
    assign pop_o    = popFire;
    assign data_o   = mem_q[rdPtr_q];
    assign count_o  = count_q;

    // Pointer and count next-state; pointers wrap naturally at the depth.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q + {{AW{1'b0}}, pushFire} - {{AW{1'b0}}, popFire};
        if (pushFire) begin
            wrPtr_d = wrPtr_q + {{(AW-1){1'b0}}, 1'b1};
        end
        if (popFire) begin
            rdPtr_d = rdPtr_q + {{(AW-1){1'b0}}, 1'b1};
        end
    end

    // Control state; reset empties the FIFO immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; stale entries are never visible while empty.
    always_ff @(posedge clk) begin
        if (pushFire) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

endmodule

// File: rtl/dmem_mmio.sv
// -----------------------------------------------------------------------------
// dmem_mmio
// Data-memory stage: word RAM plus a small MMIO block (transmit FIFO, cycle
// counter, dropped-byte counter). Loads are combinational from the address.
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset (RAM contents are kept)
//   bus    dmem_mmio_if.slave: addr/wdata/we in, rdata out,
//          tx_data/tx_valid out, tx_ready in
// -----------------------------------------------------------------------------
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int DATA_W  = DMEM_DATA_W,
    parameter int RAM_AW  = DMEM_RAM_AW,
    parameter int FIFO_AW = DMEM_FIFO_AW
) (
    input  logic        clk,
    input  logic        rst_n,
    dmem_mmio_if.slave  bus
);
    localparam int RAM_DEPTH = 1 << RAM_AW;

    logic [DATA_W-1:0] ram_q [RAM_DEPTH];
    logic [RAM_AW-1:0] ramIdx;
    dmemSel_e          sel;

    logic [DATA_W-1:0] cycle_q, cycle_d;
    logic [DATA_W-1:0] drops_q, drops_d;

    logic              txPush;
    logic              txAccept;
    logic              txPop;
    logic [FIFO_AW:0]  txCount;
    logic              txFull;
    logic              txEmpty;
    logic [DATA_W-1:0] status;
    logic              unusedAddrBits;

    // Byte offset is ignored: all accesses are whole words.
    assign unusedAddrBits = &{1'b0, bus.addr[1:0]};
    assign ramIdx         = bus.addr[RAM_AW+1:2];

    // Address decode. RAM aliases its upper bits; MMIO decodes the full word
    // address so that unmapped MMIO locations fall through to SEL_NONE.
    always_comb begin
        sel = SEL_NONE;
        if (!bus.addr[DATA_W-1]) begin
            sel = SEL_RAM;
        end else if (bus.addr[DATA_W-1:2] == MMIO_TXDATA[DATA_W-1:2]) begin
            sel = SEL_TXDATA;
        end else if (bus.addr[DATA_W-1:2] == MMIO_STATUS[DATA_W-1:2]) begin
            sel = SEL_STATUS;
        end else if (bus.addr[DATA_W-1:2] == MMIO_CYCLE[DATA_W-1:2]) begin
            sel = SEL_CYCLE;
        end else if (bus.addr[DATA_W-1:2] == MMIO_DROPS[DATA_W-1:2]) begin
            sel = SEL_DROPS;
        end
    end

    assign txPush = bus.we && (sel == SEL_TXDATA);

    tx_fifo #(
        .WIDTH (8),
        .AW    (FIFO_AW)
    ) u_tx_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_i   (txPush),
        .data_i   (bus.wdata[7:0]),
        .popReq_i (bus.tx_ready),
        .accept_o (txAccept),
        .pop_o    (txPop),
        .data_o   (bus.tx_data),
        .count_o  (txCount),
        .full_o   (txFull),
        .empty_o  (txEmpty)
    );

    assign bus.tx_valid = ~txEmpty;

    // RAM: synchronous write, asynchronous read, no reset.
    always_ff @(posedge clk) begin
        if (bus.we && (sel == SEL_RAM)) begin
            ram_q[ramIdx] <= bus.wdata;
        end
    end

    // Counter next-state. A CYCLE write replaces that cycle's increment; the
    // drop counter saturates instead of wrapping. txPop is informational only.
    always_comb begin
        cycle_d = cycle_q + {{(DATA_W-1){1'b0}}, 1'b1};
        if (bus.we && (sel == SEL_CYCLE)) begin
            cycle_d = bus.wdata;
        end
        drops_d = drops_q;
        if (bus.we && (sel == SEL_DROPS)) begin
            drops_d = '0;
        end else if (txPush && !txAccept && (drops_q != '1)) begin
            drops_d = drops_q + {{(DATA_W-1){1'b0}}, 1'b1};
        end
    end

    // Counter registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= '0;
            drops_q <= '0;
        end else begin
            cycle_q <= cycle_d;
            drops_q <= drops_d;
        end
    end

    // STATUS shows the registered FIFO state, before this cycle's push/pop.
    always_comb begin
        status = '0;
        status[STATUS_EMPTY_BIT] = txEmpty;
        status[STATUS_FULL_BIT]  = txFull;
        status[STATUS_COUNT_LSB +: FIFO_AW+1] = txCount;
    end

    // Load data mux.
    always_comb begin
        bus.rdata = '0;
        case (sel)
            SEL_RAM:    bus.rdata = ram_q[ramIdx];
            SEL_STATUS: bus.rdata = status;
            SEL_CYCLE:  bus.rdata = cycle_q;
            SEL_DROPS:  bus.rdata = drops_q;
            default:    bus.rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// -----------------------------------------------------------------------------
// tb_dmem_mmio
// Directed bench for dmem_mmio: RAM store/load and aliasing, transmit FIFO
// fill/drain and full+push+pop, CYCLE and DROPS registers, asynchronous
// reset mid-drain, and unmapped MMIO accesses.
// Inputs change 1 ns after the rising edge and outputs are sampled a few ns
// later, well before the next edge.
// -----------------------------------------------------------------------------
module tb_dmem_mmio;
    import dmem_mmio_pkg::*;

    logic clk;
    logic rst_n;
    int   assertCount;
    int   failCount;

    dmem_mmio_if #(.DATA_W(32)) busIf ();

    dmem_mmio dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busIf)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guards against a run that never reaches its summary.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drive every master-side input at once.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                                 input logic w, input logic rdy);
        busIf.addr     = a;
        busIf.wdata    = d;
        busIf.we       = w;
        busIf.tx_ready = rdy;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Present a load address (no store) and sample rdata 1 ns later.
    task automatic readReg(input logic [31:0] a, output logic [31:0] v);
        busIf.addr  = a;
        busIf.wdata = '0;
        busIf.we    = 1'b0;
        #1;
        v = busIf.rdata;
    endtask

    task automatic pushByte(input logic [7:0] b);
        applyStimulus(MMIO_TXDATA, {24'h0, b}, 1'b1, 1'b0);
        nextCycle();
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] cycA;
        logic [31:0] cycB;
        logic [7:0]  expSeq [4];

        assertCount = 0;
        failCount   = 0;
        rst_n       = 1'b0;
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);

        // ---- Reset state -------------------------------------------------
        nextCycle();
        checkOutput("rst_tx_valid", {31'h0, busIf.tx_valid}, 32'h0);
        readReg(MMIO_STATUS, v);  checkOutput("rst_status", v, 32'h1);
        readReg(MMIO_CYCLE, v);   checkOutput("rst_cycle", v, 32'h0);
        readReg(MMIO_DROPS, v);   checkOutput("rst_drops", v, 32'h0);
        readReg(MMIO_TXDATA, v);  checkOutput("rst_txdata", v, 32'h0);
        rst_n = 1'b1;
        nextCycle();

        // ---- RAM store/load, same-cycle old value, alias -----------------
        applyStimulus(32'h0000_0010, 32'hAAAA_5555, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(32'h0000_0010, 32'h1234_5678, 1'b1, 1'b0);
        #1;
        checkOutput("ram_same_cycle_old", busIf.rdata, 32'hAAAA_5555);
        nextCycle();
        readReg(32'h0000_0010, v); checkOutput("ram_read", v, 32'h1234_5678);
        readReg(32'h0000_0410, v); checkOutput("ram_alias", v, 32'h1234_5678);
        applyStimulus(32'h0000_0014, 32'hCAFE_F00D, 1'b1, 1'b0);
        nextCycle();
        readReg(32'h0000_0014, v); checkOutput("ram_read2", v, 32'hCAFE_F00D);
        readReg(32'h0000_0010, v); checkOutput("ram_neighbor", v, 32'h1234_5678);

        // ---- FIFO fill with one drop, then drain -------------------------
        for (int i = 0; i < 5; i++) begin
            applyStimulus(MMIO_TXDATA, 32'h41 + i, 1'b1, 1'b0);
            if (i == 0) begin
                #1;
                checkOutput("tx_valid_no_fallthrough", {31'h0, busIf.tx_valid}, 32'h0);
            end
            nextCycle();
            if (i == 0) begin
                checkOutput("tx_valid_after_push", {31'h0, busIf.tx_valid}, 32'h1);
            end
        end
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);
        readReg(MMIO_STATUS, v); checkOutput("fill_status", v, 32'h0000_0402);
        readReg(MMIO_DROPS, v);  checkOutput("fill_drops", v, 32'h1);
        checkOutput("fill_head", {24'h0, busIf.tx_data}, 32'h41);
        nextCycle();
        checkOutput("hold_head", {24'h0, busIf.tx_data}, 32'h41);
        checkOutput("hold_valid", {31'h0, busIf.tx_valid}, 32'h1);
        busIf.tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("drain_valid", {31'h0, busIf.tx_valid}, 32'h1);
            checkOutput("drain_data", {24'h0, busIf.tx_data}, 32'h41 + i);
            nextCycle();
        end
        checkOutput("drain_empty_valid", {31'h0, busIf.tx_valid}, 32'h0);
        readReg(MMIO_STATUS, v); checkOutput("drain_status", v, 32'h1);
        busIf.tx_ready = 1'b0;

        // ---- Full + push + pop in the same cycle -------------------------
        for (int i = 0; i < 4; i++) begin
            pushByte(8'h61 + 8'(i));
        end
        applyStimulus(MMIO_TXDATA, 32'h55, 1'b1, 1'b1);
        #1;
        checkOutput("fpp_head", {24'h0, busIf.tx_data}, 32'h61);
        nextCycle();
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);
        readReg(MMIO_STATUS, v); checkOutput("fpp_status", v, 32'h0000_0402);
        readReg(MMIO_DROPS, v);  checkOutput("fpp_drops", v, 32'h1);
        expSeq = '{8'h62, 8'h63, 8'h64, 8'h55};
        busIf.tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("fpp_drain", {24'h0, busIf.tx_data}, {24'h0, expSeq[i]});
            nextCycle();
        end
        checkOutput("fpp_empty", {31'h0, busIf.tx_valid}, 32'h0);
        busIf.tx_ready = 1'b0;

        // ---- Asynchronous reset mid-drain --------------------------------
        for (int i = 0; i < 3; i++) begin
            pushByte(8'h71 + 8'(i));
        end
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);
        readReg(MMIO_STATUS, v); checkOutput("pre_rst_status", v, 32'h0000_0300);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_tx_valid", {31'h0, busIf.tx_valid}, 32'h0);
        readReg(MMIO_STATUS, v);   checkOutput("arst_status", v, 32'h1);
        readReg(MMIO_CYCLE, v);    checkOutput("arst_cycle", v, 32'h0);
        readReg(MMIO_DROPS, v);    checkOutput("arst_drops", v, 32'h0);
        readReg(32'h0000_0010, v); checkOutput("arst_ram", v, 32'h1234_5678);
        nextCycle();
        readReg(32'h0000_0014, v); checkOutput("arst_ram2", v, 32'hCAFE_F00D);
        rst_n = 1'b1;
        nextCycle();

        // ---- DROPS clear and STATUS write ignored ------------------------
        for (int i = 0; i < 5; i++) begin
            pushByte(8'h81 + 8'(i));
        end
        readReg(MMIO_DROPS, v); checkOutput("drops_count", v, 32'h1);
        applyStimulus(MMIO_DROPS, 32'h0000_1234, 1'b1, 1'b0);
        nextCycle();
        readReg(MMIO_DROPS, v); checkOutput("drops_cleared", v, 32'h0);
        applyStimulus(MMIO_STATUS, 32'hFFFF_FFFF, 1'b1, 1'b0);
        nextCycle();
        readReg(MMIO_STATUS, v); checkOutput("status_write_ignored", v, 32'h0000_0402);
        busIf.tx_ready = 1'b1;
        repeat (4) nextCycle();
        busIf.tx_ready = 1'b0;
        readReg(MMIO_STATUS, v); checkOutput("status_empty_again", v, 32'h1);

        // ---- CYCLE counter: delta and wrap -------------------------------
        readReg(MMIO_CYCLE, cycA);
        repeat (3) nextCycle();
        #1;
        readReg(MMIO_CYCLE, cycB);
        checkOutput("cycle_delta", cycB - cycA, 32'h3);
        nextCycle();
        applyStimulus(MMIO_CYCLE, 32'hFFFF_FFFE, 1'b1, 1'b0);
        nextCycle();
        readReg(MMIO_CYCLE, v); checkOutput("cycle_loaded", v, 32'hFFFF_FFFE);
        nextCycle();
        readReg(MMIO_CYCLE, v); checkOutput("cycle_max", v, 32'hFFFF_FFFF);
        nextCycle();
        readReg(MMIO_CYCLE, v); checkOutput("cycle_wrap", v, 32'h0);

        // ---- Unmapped MMIO ----------------------------------------------
        applyStimulus(32'h8000_0020, 32'hDEAD_BEEF, 1'b1, 1'b0);
        nextCycle();
        readReg(32'h8000_0020, v); checkOutput("unmapped_read", v, 32'h0);
        readReg(MMIO_STATUS, v);   checkOutput("unmapped_status", v, 32'h1);
        readReg(MMIO_DROPS, v);    checkOutput("unmapped_drops", v, 32'h0);
        readReg(32'h0000_0010, v); checkOutput("unmapped_ram", v, 32'h1234_5678);
        checkOutput("unmapped_tx_valid", {31'h0, busIf.tx_valid}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
